// File: rtl/pov_spi_master.sv
// SPI mode-0 feeder for the rbzero POV vector slave: one pending set, one frame in flight.
// Frame = {playerX, playerY, facingX, facingY, vplaneX, vplaneY}, MSB first; all outputs registered.
module pov_spi_master #(
  parameter int VEC_BITS = 15,
  parameter int HALF     = 2,
  parameter int GAP      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [VEC_BITS-1:0] i_playerX,
  input  logic [VEC_BITS-1:0] i_playerY,
  input  logic [VEC_BITS-1:0] i_facingX,
  input  logic [VEC_BITS-1:0] i_facingY,
  input  logic [VEC_BITS-1:0] i_vplaneX,
  input  logic [VEC_BITS-1:0] i_vplaneY,
  output logic                o_sclk,
  output logic                o_mosi,
  output logic                o_ss_n,
  output logic                o_busy,
  output logic                o_done
);
  localparam int N    = 6 * VEC_BITS;
  localparam int BW   = $clog2(N + 1);
  localparam int HMAX = (HALF > GAP) ? HALF : GAP;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [HW-1:0] HALF_END = HW'(HALF - 1);
  localparam logic [HW-1:0] GAP_END  = HW'(GAP - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(N);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_HIGH, S_LOW, S_GAP} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic [N-1:0]  shreg, shreg_nxt;
  logic [N-1:0]  pend, pend_nxt;
  logic          pend_full, pend_full_nxt;
  logic          sclk_nxt, mosi_nxt, ss_n_nxt, busy_nxt, done_nxt;
  logic          hdone;

  assign hdone = (hcnt == HALF_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      hcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      o_ready   <= 1'b1;
      o_sclk    <= 1'b0;
      o_mosi    <= 1'b0;
      o_ss_n    <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_nxt;
      hcnt      <= hcnt_nxt;
      bcnt      <= bcnt_nxt;
      shreg     <= shreg_nxt;
      pend      <= pend_nxt;
      pend_full <= pend_full_nxt;
      o_ready   <= ~pend_full_nxt;
      o_sclk    <= sclk_nxt;
      o_mosi    <= mosi_nxt;
      o_ss_n    <= ss_n_nxt;
      o_busy    <= busy_nxt;
      o_done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    hcnt_nxt      = hcnt;
    bcnt_nxt      = bcnt;
    shreg_nxt     = shreg;
    pend_nxt      = pend;
    pend_full_nxt = pend_full;
    sclk_nxt      = o_sclk;
    mosi_nxt      = o_mosi;
    ss_n_nxt      = o_ss_n;
    busy_nxt      = o_busy;
    done_nxt      = 1'b0;

    // Accept and load are exclusive: accept needs the slot empty, load needs it full.
    if (i_valid && !pend_full) begin
      pend_nxt      = {i_playerX, i_playerY, i_facingX, i_facingY, i_vplaneX, i_vplaneY};
      pend_full_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (pend_full) begin
          state_nxt     = S_LEAD;
          hcnt_nxt      = '0;
          bcnt_nxt      = '0;
          shreg_nxt     = pend;
          pend_full_nxt = 1'b0;
          ss_n_nxt      = 1'b0;
          sclk_nxt      = 1'b0;
          busy_nxt      = 1'b1;
          mosi_nxt      = pend[N-1];
        end
      end
      S_LEAD: begin
        if (hdone) begin
          state_nxt = S_HIGH;
          hcnt_nxt  = '0;
          sclk_nxt  = 1'b1;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (hdone) begin
          // Zero fill means the LOW after the last bit drives mosi=0 on its own.
          state_nxt = S_LOW;
          hcnt_nxt  = '0;
          sclk_nxt  = 1'b0;
          shreg_nxt = {shreg[N-2:0], 1'b0};
          mosi_nxt  = shreg[N-2];
          bcnt_nxt  = bcnt + 1'b1;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      S_LOW: begin
        if (hdone) begin
          hcnt_nxt = '0;
          if (bcnt == LAST_BIT) begin
            state_nxt = S_GAP;
            ss_n_nxt  = 1'b1;
            done_nxt  = 1'b1;
            mosi_nxt  = 1'b0;
          end else begin
            state_nxt = S_HIGH;
            sclk_nxt  = 1'b1;
          end
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      S_GAP: begin
        if (hcnt == GAP_END) begin
          state_nxt = S_IDLE;
          hcnt_nxt  = '0;
          busy_nxt  = 1'b0;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_pov_spi_master.sv
// Bench for pov_spi_master: dut0 at default timing, dut1 built with HALF=1 GAP=1.
`timescale 1ns/1ps
module tb_pov_spi_master;
  localparam int VB = 15;
  localparam int N  = 6 * VB;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [1:0]   rst, valid, ready, sclk, mosi, ss_n, busy, done;
  logic [N-1:0] win [2];

  pov_spi_master dut0 (
    .clk(clk), .reset(rst[0]), .i_valid(valid[0]), .o_ready(ready[0]),
    .i_playerX(win[0][89:75]), .i_playerY(win[0][74:60]), .i_facingX(win[0][59:45]),
    .i_facingY(win[0][44:30]), .i_vplaneX(win[0][29:15]), .i_vplaneY(win[0][14:0]),
    .o_sclk(sclk[0]), .o_mosi(mosi[0]), .o_ss_n(ss_n[0]), .o_busy(busy[0]), .o_done(done[0]));

  pov_spi_master #(.VEC_BITS(VB), .HALF(1), .GAP(1)) dut1 (
    .clk(clk), .reset(rst[1]), .i_valid(valid[1]), .o_ready(ready[1]),
    .i_playerX(win[1][89:75]), .i_playerY(win[1][74:60]), .i_facingX(win[1][59:45]),
    .i_facingY(win[1][44:30]), .i_vplaneX(win[1][29:15]), .i_vplaneY(win[1][14:0]),
    .o_sclk(sclk[1]), .o_mosi(mosi[1]), .o_ss_n(ss_n[1]), .o_busy(busy[1]), .o_done(done[1]));

  function automatic int half_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction
  function automatic int gap_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction
  function automatic logic [N-1:0] rand_set();
    logic [VB-1:0] v [6];
    for (int k = 0; k < 6; k++) v[k] = VB'($urandom_range(0, (1 << VB) - 1));
    return {v[0], v[1], v[2], v[3], v[4], v[5]};
  endfunction

  // Behavioural SPI slave: shifts mosi on sclk rising edges while ss_n is low.
  logic [N-1:0] cur_dat [2];
  int cur_bits [2], cur_low [2], cur_fall [2], cur_stuck [2];
  logic [N-1:0] rec_dat [2][32];
  int rec_bits [2][32], rec_low [2][32], rec_fall [2][32], rec_rise [2][32], rec_stuck [2][32];
  logic rec_done [2][32];
  int rec_n [2], done_cnt [2];
  logic prev_ss [2], prev_sclk [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      rec_n[d] = 0; done_cnt[d] = 0; prev_ss[d] = 1'b1; prev_sclk[d] = 1'b0;
      cur_bits[d] = 0; cur_low[d] = 0; cur_fall[d] = 0; cur_stuck[d] = 0; cur_dat[d] = '0;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (ss_n[d] === 1'b0) begin
        if (prev_ss[d]) begin
          cur_fall[d] = cyc; cur_low[d] = 0; cur_bits[d] = 0; cur_stuck[d] = 0; cur_dat[d] = '0;
        end else if (sclk[d] === prev_sclk[d]) begin
          cur_stuck[d]++;
        end
        cur_low[d]++;
        if (sclk[d] === 1'b1 && prev_sclk[d] === 1'b0) begin
          cur_dat[d] = {cur_dat[d][N-2:0], mosi[d]};
          cur_bits[d]++;
        end
      end else if (ss_n[d] === 1'b1 && prev_ss[d] === 1'b0 && rec_n[d] < 32) begin
        rec_dat[d][rec_n[d]]   = cur_dat[d];
        rec_bits[d][rec_n[d]]  = cur_bits[d];
        rec_low[d][rec_n[d]]   = cur_low[d];
        rec_fall[d][rec_n[d]]  = cur_fall[d];
        rec_rise[d][rec_n[d]]  = cyc;
        rec_stuck[d][rec_n[d]] = cur_stuck[d];
        rec_done[d][rec_n[d]]  = done[d];
        rec_n[d]++;
      end
      if (done[d] === 1'b1) done_cnt[d]++;
      prev_ss[d]   = ss_n[d];
      prev_sclk[d] = sclk[d];
    end
  end

  // Called at a negedge; holds i_valid until the set is taken, returns the accept cycle.
  task automatic offer(input int d, input logic [N-1:0] w, output int acc);
    valid[d] = 1'b1;
    win[d]   = w;
    acc      = -1;
    for (int i = 0; i < 3000; i++) begin
      if (ready[d] === 1'b1) begin acc = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    valid[d] = 1'b0;
    win[d]   = rand_set();
    checks++;
    if (acc < 0) begin errors++; $display("FAIL accept_timeout dut%0d: no accept, required within 3000 cycles", d); end
  endtask

  task automatic wait_recs(input int d, input int n);
    int t = 0;
    while (rec_n[d] < n && t < 3000) begin @(negedge clk); t++; end
    checks++;
    if (rec_n[d] < n) begin errors++; $display("FAIL frame_timeout dut%0d: frames=%0d required=%0d", d, rec_n[d], n); end
  endtask

  task automatic test_reset();
    rst = 2'b11; valid = 2'b00; win[0] = '0; win[1] = '0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (ss_n !== 2'b11)  begin errors++; $display("FAIL reset_ss_n: got %b required 11", ss_n); end
    if (sclk !== 2'b00)  begin errors++; $display("FAIL reset_sclk: got %b required 00", sclk); end
    if (mosi !== 2'b00)  begin errors++; $display("FAIL reset_mosi: got %b required 00", mosi); end
    if (ready !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b required 11", ready); end
    if (busy !== 2'b00)  begin errors++; $display("FAIL reset_busy: got %b required 00", busy); end
    if (done !== 2'b00)  begin errors++; $display("FAIL reset_done: got %b required 00", done); end
    rst = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [N-1:0] w;
    int acc, b, dc, r;
    w  = {15'h1234, 15'h0001, 15'h7FFF, 15'h4000, 15'h0000, 15'h2AAA};
    b  = rec_n[0]; dc = done_cnt[0];
    offer(0, w, acc);
    checks += 2;
    if (ready[0] !== 1'b0) begin errors++; $display("FAIL single_ready_fall: got %b required 0", ready[0]); end
    if (ss_n[0] !== 1'b1)  begin errors++; $display("FAIL single_ss_early: got %b required 1", ss_n[0]); end
    @(negedge clk);
    checks += 3;
    if (ss_n[0] !== 1'b0)  begin errors++; $display("FAIL single_ss_low: got %b required 0", ss_n[0]); end
    if (ready[0] !== 1'b1) begin errors++; $display("FAIL single_ready_rise: got %b required 1", ready[0]); end
    if (busy[0] !== 1'b1)  begin errors++; $display("FAIL single_busy: got %b required 1", busy[0]); end
    wait_recs(0, b + 1);
    r = rec_rise[0][b];
    checks += 5;
    if (rec_fall[0][b] - acc != 2) begin errors++; $display("FAIL single_latency: got %0d required 2", rec_fall[0][b] - acc); end
    if (rec_bits[0][b] != N) begin errors++; $display("FAIL single_bits: got %0d required %0d", rec_bits[0][b], N); end
    if (rec_dat[0][b] !== w) begin errors++; $display("FAIL single_data: got %h required %h", rec_dat[0][b], w); end
    if (rec_low[0][b] != 2 * (2 * N + 1)) begin errors++; $display("FAIL single_low: got %0d required %0d", rec_low[0][b], 2 * (2 * N + 1)); end
    if (rec_done[0][b] !== 1'b1) begin errors++; $display("FAIL single_done_at_rise: got %b required 1", rec_done[0][b]); end
    while (cyc < r + gap_of(0) - 1) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL single_busy_gap: got %b required 1", busy[0]); end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b required 0", busy[0]); end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt[0] - dc != 1) begin errors++; $display("FAIL single_done_count: got %0d required 1", done_cnt[0] - dc); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] wa, wb;
    int acca, accb, b, rr;
    wa = rand_set(); wb = rand_set(); b = rec_n[0];
    offer(0, wa, acca);
    while (cyc < acca + 10) @(negedge clk);
    offer(0, wb, accb);
    rr = -1;
    for (int i = 0; i < 2000; i++) begin
      if (ready[0] === 1'b1) begin rr = cyc; break; end
      @(negedge clk);
    end
    wait_recs(0, b + 2);
    checks += 6;
    if (accb != acca + 10) begin errors++; $display("FAIL b2b_accept_b: got %0d required %0d", accb, acca + 10); end
    if (rr != rec_fall[0][b + 1]) begin errors++; $display("FAIL b2b_ready_rise: got %0d required %0d", rr, rec_fall[0][b + 1]); end
    if (rec_fall[0][b + 1] - rec_rise[0][b] != gap_of(0) + 1) begin errors++;
      $display("FAIL b2b_gap: got %0d required %0d", rec_fall[0][b + 1] - rec_rise[0][b], gap_of(0) + 1); end
    if (rec_dat[0][b] !== wa) begin errors++; $display("FAIL b2b_data_a: got %h required %h", rec_dat[0][b], wa); end
    if (rec_dat[0][b + 1] !== wb) begin errors++; $display("FAIL b2b_data_b: got %h required %h", rec_dat[0][b + 1], wb); end
    if (rec_bits[0][b + 1] != N) begin errors++; $display("FAIL b2b_bits_b: got %0d required %0d", rec_bits[0][b + 1], N); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_stall();
    logic [N-1:0] w [3];
    int acc [3];
    int b, startc;
    b = rec_n[0];
    for (int k = 0; k < 3; k++) w[k] = rand_set();
    offer(0, w[0], acc[0]);
    offer(0, w[1], acc[1]);
    startc = cyc;
    offer(0, w[2], acc[2]);
    wait_recs(0, b + 3);
    checks += 2;
    if (acc[2] != rec_fall[0][b + 1]) begin errors++; $display("FAIL stall_accept_c: got %0d required %0d", acc[2], rec_fall[0][b + 1]); end
    if (acc[2] - startc < 300) begin errors++; $display("FAIL stall_hold: got %0d required >=300", acc[2] - startc); end
    for (int k = 0; k < 3; k++) begin
      checks += 2;
      if (rec_dat[0][b + k] !== w[k]) begin errors++; $display("FAIL stall_data%0d: got %h required %h", k, rec_dat[0][b + k], w[k]); end
      if (rec_bits[0][b + k] != N) begin errors++; $display("FAIL stall_bits%0d: got %0d required %0d", k, rec_bits[0][b + k], N); end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] wa, wb, wc;
    int acc, b, dc, t;
    wa = rand_set(); wb = rand_set(); wc = rand_set();
    b = rec_n[0]; dc = done_cnt[0];
    offer(0, wa, acc);
    offer(0, wb, acc);
    t = 0;
    while (!(ss_n[0] === 1'b0 && cur_bits[0] == 40) && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (t >= 2000) begin errors++; $display("FAIL midrst_reach_bit40: bits=%0d required 40", cur_bits[0]); end
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    checks += 5;
    if (ss_n[0] !== 1'b1)  begin errors++; $display("FAIL midrst_ss_n: got %b required 1", ss_n[0]); end
    if (sclk[0] !== 1'b0)  begin errors++; $display("FAIL midrst_sclk: got %b required 0", sclk[0]); end
    if (ready[0] !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b required 1", ready[0]); end
    if (busy[0] !== 1'b0)  begin errors++; $display("FAIL midrst_busy: got %b required 0", busy[0]); end
    if (done[0] !== 1'b0)  begin errors++; $display("FAIL midrst_done: got %b required 0", done[0]); end
    repeat (10) @(negedge clk);
    checks += 4;
    if (ss_n[0] !== 1'b1) begin errors++; $display("FAIL midrst_pending_cleared: ss_n=%b required 1", ss_n[0]); end
    if (done_cnt[0] != dc) begin errors++; $display("FAIL midrst_no_done: got %0d required %0d", done_cnt[0], dc); end
    if (rec_n[0] != b + 1) begin errors++; $display("FAIL midrst_frames: got %0d required %0d", rec_n[0], b + 1); end
    if (rec_bits[0][b] != 40) begin errors++; $display("FAIL midrst_abort_bits: got %0d required 40", rec_bits[0][b]); end
    offer(0, wc, acc);
    wait_recs(0, b + 2);
    checks += 3;
    if (rec_dat[0][b + 1] !== wc) begin errors++; $display("FAIL midrst_new_data: got %h required %h", rec_dat[0][b + 1], wc); end
    if (rec_bits[0][b + 1] != N) begin errors++; $display("FAIL midrst_new_bits: got %0d required %0d", rec_bits[0][b + 1], N); end
    if (rec_low[0][b + 1] != 2 * (2 * N + 1)) begin errors++; $display("FAIL midrst_new_low: got %0d required %0d", rec_low[0][b + 1], 2 * (2 * N + 1)); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_half1();
    logic [N-1:0] w;
    int acc, b;
    w = {15'h1234, 15'h0001, 15'h7FFF, 15'h4000, 15'h0000, 15'h2AAA};
    b = rec_n[1];
    offer(1, w, acc);
    wait_recs(1, b + 1);
    checks += 6;
    if (rec_fall[1][b] - acc != 2) begin errors++; $display("FAIL half1_latency: got %0d required 2", rec_fall[1][b] - acc); end
    if (rec_low[1][b] != 2 * N + 1) begin errors++; $display("FAIL half1_low: got %0d required %0d", rec_low[1][b], 2 * N + 1); end
    if (rec_bits[1][b] != N) begin errors++; $display("FAIL half1_bits: got %0d required %0d", rec_bits[1][b], N); end
    if (rec_dat[1][b] !== w) begin errors++; $display("FAIL half1_data: got %h required %h", rec_dat[1][b], w); end
    if (rec_stuck[1][b] != 0) begin errors++; $display("FAIL half1_toggle: non-toggling cycles=%0d required 0", rec_stuck[1][b]); end
    if (rec_done[1][b] !== 1'b1) begin errors++; $display("FAIL half1_done: got %b required 1", rec_done[1][b]); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_random(input int d, input int n);
    logic [N-1:0] w [8];
    int acc, b;
    b = rec_n[d];
    for (int k = 0; k < n; k++) begin
      w[k] = rand_set();
      offer(d, w[k], acc);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_recs(d, b + n);
    for (int k = 0; k < n; k++) begin
      checks += 3;
      if (rec_dat[d][b + k] !== w[k]) begin errors++; $display("FAIL rand%0d_data%0d: got %h required %h", d, k, rec_dat[d][b + k], w[k]); end
      if (rec_bits[d][b + k] != N) begin errors++; $display("FAIL rand%0d_bits%0d: got %0d required %0d", d, k, rec_bits[d][b + k], N); end
      if (rec_low[d][b + k] != half_of(d) * (2 * N + 1)) begin errors++;
        $display("FAIL rand%0d_low%0d: got %0d required %0d", d, k, rec_low[d][b + k], half_of(d) * (2 * N + 1)); end
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_half1();
    test_random(1, 5);
    test_random(0, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
